// File: rtl/eth_tx_framer.sv
// Ethernet II transmit framer: preamble/SFD, MAC header, padded payload, FCS from the external CRC stage, then IFG.
// First preamble byte one cycle after an accepted start; no backpressure, tx_req pulls payload two cycles ahead of the wire.
module eth_tx_framer #(
  parameter logic [47:0] DES_MAC  = 48'hff_ff_ff_ff_ff_ff,
  parameter logic [47:0] SRC_MAC  = 48'h00_11_22_33_44_55,
  parameter logic [15:0] ETH_TYPE = 16'h0800,
  parameter int          IFG_CYC  = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start_en,
  input  logic [15:0] tx_byte_num,
  output logic        tx_req,
  input  logic [7:0]  tx_data,
  input  logic [31:0] crc_out,
  output logic        crc_en,
  output logic        crc_clr,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd,
  output logic        tx_busy,
  output logic        tx_done
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_PAY, S_FCS, S_IFG} state_t;

  localparam logic [111:0] HDR      = {DES_MAC, SRC_MAC, ETH_TYPE};
  localparam logic [10:0]  MAX_LEN  = 11'd1500;
  localparam logic [10:0]  MIN_PAY  = 11'd46;
  localparam logic [10:0]  IFG_LAST = 11'(IFG_CYC - 1);

  state_t         r_state;
  logic [10:0]    r_cnt;
  logic [10:0]    r_len;
  logic [10:0]    r_pay_total;
  logic [10:0]    r_req_rem;
  logic [111:0]   r_hdr_sr;
  logic [7:0]     r_txd;
  logic           r_tx_en;
  logic           r_crc_en;
  logic           r_crc_clr;
  logic           r_req;
  logic           r_busy;
  logic           r_done;
  logic           r_fcs_sel;

  logic [10:0]    w_len;
  logic [10:0]    w_pay_total;
  logic [7:0]     w_fcs_byte;

  always_comb begin
    w_len       = (tx_byte_num > 16'd1500) ? MAX_LEN : tx_byte_num[10:0];
    w_pay_total = (w_len < MIN_PAY) ? MIN_PAY : w_len;
    case (r_cnt[1:0])
      2'd0:    w_fcs_byte = crc_out[31:24];
      2'd1:    w_fcs_byte = crc_out[23:16];
      2'd2:    w_fcs_byte = crc_out[15:8];
      default: w_fcs_byte = crc_out[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_len       <= '0;
      r_pay_total <= '0;
      r_req_rem   <= '0;
      r_hdr_sr    <= '0;
      r_txd       <= '0;
      r_tx_en     <= 1'b0;
      r_crc_en    <= 1'b0;
      r_crc_clr   <= 1'b1;
      r_req       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fcs_sel   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_crc_clr <= 1'b0;
      if (r_req) begin
        if (r_req_rem != 11'd0) r_req_rem <= r_req_rem - 11'd1;
        else                    r_req     <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (tx_start_en) begin
            r_state     <= S_PRE;
            r_cnt       <= '0;
            r_len       <= w_len;
            r_pay_total <= w_pay_total;
            r_tx_en     <= 1'b1;
            r_txd       <= 8'h55;
            r_busy      <= 1'b1;
          end
        end

        S_PRE: begin
          if (r_cnt == 11'd7) begin
            r_state  <= S_HDR;
            r_cnt    <= '0;
            r_txd    <= HDR[111:104];
            r_hdr_sr <= {HDR[103:0], 8'h00};
            r_crc_en <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 11'd1;
            r_txd <= (r_cnt == 11'd6) ? 8'hD5 : 8'h55;
          end
        end

        S_HDR: begin
          // Requests start at header byte 12 so byte 0 is back in time for the first payload slot.
          if (r_cnt == 11'd11 && r_len != 11'd0) begin
            r_req     <= 1'b1;
            r_req_rem <= r_len - 11'd1;
          end
          if (r_cnt == 11'd13) begin
            r_state <= S_PAY;
            r_cnt   <= '0;
            r_txd   <= (r_len != 11'd0) ? tx_data : 8'h00;
          end else begin
            r_cnt    <= r_cnt + 11'd1;
            r_txd    <= r_hdr_sr[111:104];
            r_hdr_sr <= {r_hdr_sr[103:0], 8'h00};
          end
        end

        S_PAY: begin
          if (r_cnt == r_pay_total - 11'd1) begin
            r_state   <= S_FCS;
            r_cnt     <= '0;
            r_crc_en  <= 1'b0;
            r_fcs_sel <= 1'b1;
            r_txd     <= 8'h00;
          end else begin
            r_cnt <= r_cnt + 11'd1;
            r_txd <= ((r_cnt + 11'd1) < r_len) ? tx_data : 8'h00;
          end
        end

        S_FCS: begin
          if (r_cnt == 11'd3) begin
            r_state   <= S_IFG;
            r_cnt     <= '0;
            r_tx_en   <= 1'b0;
            r_fcs_sel <= 1'b0;
            r_done    <= 1'b1;
            r_crc_clr <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 11'd1;
          end
        end

        S_IFG: begin
          if (r_cnt == IFG_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 11'd1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The CRC stage only settles after the last payload byte, so FCS bytes are muxed straight from crc_out.
  assign gmii_txd   = r_fcs_sel ? w_fcs_byte : r_txd;
  assign gmii_tx_en = r_tx_en;
  assign crc_en     = r_crc_en;
  assign crc_clr    = r_crc_clr | rst;
  assign tx_req     = r_req;
  assign tx_busy    = r_busy;
  assign tx_done    = r_done;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: a reference model queues every expected wire byte per frame,
// a monitor pops and compares while gmii_tx_en is high; the bench also plays upstream FIFO and CRC stage.
module tb_eth_tx_framer;
  localparam int IFG_CYC = 12;
  localparam logic [111:0] HDR = {48'hff_ff_ff_ff_ff_ff, 48'h00_11_22_33_44_55, 16'h0800};

  logic        clk;
  logic        rst;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic        tx_req;
  logic [7:0]  tx_data;
  logic [31:0] crc_out;
  logic        crc_en;
  logic        crc_clr;
  logic        gmii_tx_en;
  logic [7:0]  gmii_txd;
  logic        tx_busy;
  logic        tx_done;

  eth_tx_framer #(.IFG_CYC(IFG_CYC)) dut (
    .clk(clk), .rst(rst), .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num),
    .tx_req(tx_req), .tx_data(tx_data), .crc_out(crc_out), .crc_en(crc_en),
    .crc_clr(crc_clr), .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         exp_frm_q[$];
  logic [7:0] up_q[$];
  logic [31:0] crc_r;

  int cyc = 0, pos = 0, cur_n = 0, cur_m = 0, req_cnt = 0, req_first = 0, req_last = 0;
  int bw = 0, last_fall = 0, b2b_frames = 0;
  bit in_frame = 0, busy_wait = 0, mon_hold = 1, b2b_mode = 0, req_prev = 0, exp_done = 0;

  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound exceeded or rule violated (cycle %0d)", name, cyc);
  endtask

  // Reference frame: preamble, header, payload, zero pad to 46, then IEEE CRC-32 low byte first.
  task automatic push_frame(input int n, input bit inc);
    logic [7:0]   f[$];
    logic [111:0] h;
    logic [31:0]  c;
    logic [7:0]   b;
    for (int i = 0; i < 7; i++) f.push_back(8'h55);
    f.push_back(8'hD5);
    h = HDR;
    for (int k = 0; k < 14; k++) begin
      f.push_back(h[111:104]);
      h = h << 8;
    end
    for (int i = 0; i < n; i++) begin
      b = inc ? 8'(i) : 8'($urandom);
      f.push_back(b);
      up_q.push_back(b);
    end
    for (int i = n; i < 46; i++) f.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < f.size(); i++) c = crc_step(c, f[i]);
    c = ~c;
    f.push_back(c[7:0]);
    f.push_back(c[15:8]);
    f.push_back(c[23:16]);
    f.push_back(c[31:24]);
    foreach (f[i]) exp_q.push_back(f[i]);
    exp_frm_q.push_back(n);
  endtask

  // External byte-wide CRC-32 stage; presents the finished FCS so that bits [31:24] go out first.
  assign crc_out = {~crc_r[7:0], ~crc_r[15:8], ~crc_r[23:16], ~crc_r[31:24]};
  initial begin
    crc_r = 32'hFFFF_FFFF;
    forever begin
      @(negedge clk);
      if (crc_clr === 1'b1)      crc_r = 32'hFFFF_FFFF;
      else if (crc_en === 1'b1)  crc_r = crc_step(crc_r, gmii_txd);
    end
  end

  // Upstream FIFO: answers a request with data one cycle later, junk otherwise.
  initial begin
    tx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (req_prev) begin
        checks++;
        if (up_q.size() == 0) begin
          errors++;
          $display("FAIL tx_req_excess: request with no payload byte left (cycle %0d)", cyc);
          tx_data = 8'hA5;
        end else begin
          tx_data = up_q.pop_front();
        end
      end else begin
        tx_data = 8'($urandom);
      end
      req_prev = (tx_req === 1'b1);
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!b2b_mode) b2b_frames = 0;
      if (mon_hold) begin
        in_frame  = 0;
        busy_wait = 0;
      end else begin
        exp_done = in_frame && (gmii_tx_en !== 1'b1);
        if (tx_done === 1'b1 || exp_done) chk("tx_done", 32'(tx_done), 32'(exp_done));
        if (busy_wait) begin
          bw++;
          if (tx_busy !== 1'b1) begin
            chk("busy_fall_after_done", bw, IFG_CYC);
            busy_wait = 0;
          end else if (bw > IFG_CYC + 100) begin
            fail("busy_stuck");
            busy_wait = 0;
          end
        end
        if (tx_req === 1'b1 && gmii_tx_en !== 1'b1) fail("req_outside_frame");
        if (gmii_tx_en === 1'b1) begin
          if (!in_frame) begin
            if (exp_frm_q.size() == 0) begin
              fail("unexpected_frame");
              cur_n = 0;
            end else begin
              cur_n = exp_frm_q.pop_front();
            end
            if (b2b_mode && b2b_frames > 0) chk("b2b_gap", cyc - last_fall, IFG_CYC + 1);
            if (b2b_mode) b2b_frames++;
            cur_m = (cur_n < 46) ? 46 : cur_n;
            pos = 0; req_cnt = 0; req_first = -1; req_last = -1;
            in_frame = 1;
          end
          if (tx_req === 1'b1) begin
            req_cnt++;
            if (req_first < 0) req_first = pos;
            req_last = pos;
          end
          if (exp_q.size() == 0) fail($sformatf("txd_extra[%0d]", pos));
          else chk($sformatf("txd[%0d]", pos), 32'(gmii_txd), 32'(exp_q.pop_front()));
          chk($sformatf("crc_en[%0d]", pos), 32'(crc_en), 32'(pos >= 8 && pos < 22 + cur_m));
          pos++;
        end else if (in_frame) begin
          chk("frame_len", pos, 26 + cur_m);
          chk("req_count", req_cnt, cur_n);
          if (cur_n > 0) begin
            chk("req_first_pos", req_first, 20);
            chk("req_last_pos", req_last, 19 + cur_n);
          end
          chk("ifg_txd", 32'(gmii_txd), 0);
          chk("crc_clr_ifg", 32'(crc_clr), 1);
          in_frame  = 0;
          busy_wait = 1;
          bw        = 0;
          last_fall = cyc;
        end
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (!(exp_frm_q.size() == 0 && !in_frame && !busy_wait && tx_busy === 1'b0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) fail("wait_idle_timeout");
  endtask

  task automatic wait_rise();
    int t = 0;
    while (!in_frame && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_frame) fail("frame_start_timeout");
  endtask

  task automatic send_frame(input int num, input bit inc);
    wait_idle();
    push_frame((num > 1500) ? 1500 : num, inc);
    tx_byte_num = 16'(num);
    tx_start_en = 1'b1;
    @(negedge clk);
    tx_start_en = 1'b0;
  endtask

  int lens[4] = '{1, 2, 45, 47};

  initial begin
    int t;
    rst = 1'b1;
    tx_start_en = 1'b0;
    tx_byte_num = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_tx_en", 32'(gmii_tx_en), 0);
    chk("rst_busy", 32'(tx_busy), 0);
    chk("rst_req", 32'(tx_req), 0);
    chk("rst_crc_en", 32'(crc_en), 0);
    chk("rst_done", 32'(tx_done), 0);
    chk("rst_crc_clr", 32'(crc_clr), 1);
    mon_hold = 0;

    send_frame(46, 1'b1);
    send_frame(0, 1'b0);
    send_frame(1500, 1'b1);
    send_frame(1700, 1'b0);
    foreach (lens[i]) send_frame(lens[i], 1'b0);
    repeat (3) send_frame(int'($urandom_range(0, 120)), 1'b0);

    // Starts during payload and on the tx_done cycle must both be dropped.
    send_frame(60, 1'b0);
    wait_rise();
    repeat (40) @(negedge clk);
    tx_byte_num = 16'd5;
    tx_start_en = 1'b1;
    @(negedge clk);
    tx_start_en = 1'b0;
    t = 0;
    while (tx_done !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (tx_done !== 1'b1) fail("done_wait_timeout");
    tx_start_en = 1'b1;
    @(negedge clk);
    tx_start_en = 1'b0;
    wait_idle();
    repeat (60) @(negedge clk);

    // Start held high: three frames, gap is the IFG plus the idle cycle that accepts the next start.
    wait_idle();
    repeat (3) push_frame(10, 1'b0);
    b2b_mode    = 1;
    tx_byte_num = 16'd10;
    tx_start_en = 1'b1;
    t = 0;
    while (b2b_frames < 3 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (b2b_frames < 3) fail("b2b_timeout");
    tx_start_en = 1'b0;
    wait_idle();
    b2b_mode = 0;

    // Reset during the header abandons the frame.
    send_frame(30, 1'b0);
    wait_rise();
    repeat (10) @(negedge clk);
    mon_hold = 1;
    rst = 1'b1;
    #1;
    chk("crc_clr_in_rst", 32'(crc_clr), 1);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_tx_en", 32'(gmii_tx_en), 0);
    chk("midrst_busy", 32'(tx_busy), 0);
    chk("midrst_req", 32'(tx_req), 0);
    chk("midrst_crc_en", 32'(crc_en), 0);
    chk("midrst_txd", 32'(gmii_txd), 0);
    exp_q.delete();
    exp_frm_q.delete();
    up_q.delete();
    @(negedge clk);
    mon_hold = 0;
    send_frame(20, 1'b0);
    wait_idle();

    chk("leftover_bytes", 32'(exp_q.size()), 0);
    chk("leftover_payload", 32'(up_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
